first_nios2_system_lcd_sequencer: RTL

//  Avalon-MM slave that queues HD44780 command/data bytes from the Nios II and drives the

---
 rtl/first_nios2_system_lcd_sequencer.sv | 255 +++++++++++++++++++++++++
 1 files changed

// File: rtl/first_nios2_system_lcd_sequencer.sv
// HD44780 character-LCD sequencer (Avalon-MM slave). Software pushes bytes; the FSM strobes E with fixed setup/pulse/hold/wait timing.
// Build macro LCD_INIT_EN adds a power-up delay and the built-in 0x38,0x0C,0x01,0x06 init sequence.

// Byte queue between the Avalon write port and the LCD sequencer.
// Latency: a pushed entry is visible at the head on the next cycle.
// Backpressure: a push while full is ignored and a pop while empty is ignored.
module first_nios2_system_lcd_sequencer_fifo #(
  parameter int W  = 9,
  parameter int AW = 3
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         push_i,
  input  logic [W-1:0] dat_i,
  input  logic         pop_i,
  output logic [W-1:0] dat_o,
  output logic         full_o,
  output logic         empty_o,
  output logic [AW:0]  level_o
);
  logic [W-1:0]  mem_q [2**AW];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   lvl_q;
  logic          do_push, do_pop;

  assign full_o  = lvl_q[AW];
  assign empty_o = (lvl_q == '0);
  assign level_o = lvl_q;
  assign dat_o   = mem_q[rd_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= dat_i;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      lvl_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   lvl_q <= lvl_q + 1'b1;
        2'b01:   lvl_q <= lvl_q - 1'b1;
        default: lvl_q <= lvl_q;
      endcase
    end
  end
endmodule

// Queues {rs,byte} pushes and replays each one onto the LCD pins as SETUP/PULSE/HOLD/WAIT.
// Latency: a push into an empty idle queue pops next cycle; E rises T_AS cycles after the pop.
// Backpressure: none on Avalon; pushes to a full queue are dropped and flagged by the sticky ovf bit.
module first_nios2_system_lcd_sequencer #(
  parameter int T_AS     = 2,
  parameter int T_EPW    = 12,
  parameter int T_HOLD   = 2,
  parameter int CMD_WAIT = 2000,
  parameter int CLR_WAIT = 82000,
  parameter int PWR_WAIT = 750000,
  parameter int FIFO_AW  = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] address,
  input  logic       write,
  input  logic [7:0] writedata,
  input  logic       read,
  output logic [7:0] readdata,
  output logic       LCD_E,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic [7:0] LCD_data
);
  localparam int M1   = (CMD_WAIT > CLR_WAIT) ? CMD_WAIT : CLR_WAIT;
  localparam int M2   = (M1 > PWR_WAIT) ? M1 : PWR_WAIT;
  localparam int M3   = (M2 > T_EPW) ? M2 : T_EPW;
  localparam int M4   = (M3 > T_AS) ? M3 : T_AS;
  localparam int MAXP = (M4 > T_HOLD) ? M4 : T_HOLD;
  localparam int CW   = ($clog2(MAXP + 1) < 17) ? 17 : $clog2(MAXP + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_PULSE = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;
`ifdef LCD_INIT_EN
  localparam logic [2:0]    S_PWRUP   = 3'd5;
  localparam logic [2:0]    RST_STATE = S_PWRUP;
  localparam logic [CW-1:0] RST_CNT   = CW'(PWR_WAIT - 1);
`else
  localparam logic [2:0]    RST_STATE = S_IDLE;
  localparam logic [CW-1:0] RST_CNT   = '0;
`endif

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          e_q, e_d, rs_q, rs_d, ovf_q, ovf_d;
  logic [7:0]    dat_q, dat_d;
  logic          pop, issue, long_wait, busy;
  logic [8:0]    issue_dat, fifo_dat;
  logic          fifo_full, fifo_empty;
  logic [FIFO_AW:0] fifo_lvl;
  logic [3:0]    lvl_sat;
  logic          push;

  assign push = write & ~address[1];

  first_nios2_system_lcd_sequencer_fifo #(.W(9), .AW(FIFO_AW)) u_fifo (
    .clk_i   (clk),
    .rst_n_i (reset_n),
    .push_i  (push),
    .dat_i   ({address[0], writedata}),
    .pop_i   (pop),
    .dat_o   (fifo_dat),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_lvl)
  );

`ifdef LCD_INIT_EN
  logic [1:0] init_idx_q, init_idx_d;
  logic       init_pend_q, init_pend_d;
  logic [7:0] init_byte;

  always_comb begin
    init_byte = 8'h38;
    case (init_idx_q)
      2'd0:    init_byte = 8'h38;
      2'd1:    init_byte = 8'h0C;
      2'd2:    init_byte = 8'h01;
      default: init_byte = 8'h06;
    endcase
  end
  assign busy = (state_q != S_IDLE) | ~fifo_empty | init_pend_q;
`else
  assign busy = (state_q != S_IDLE) | ~fifo_empty;
`endif

  // Clear (0x01) and home (0x02/0x03) need the long execution delay.
  assign long_wait = ~rs_q & (dat_q[7:2] == 6'd0) & (dat_q != 8'd0);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    e_d       = e_q;
    rs_d      = rs_q;
    dat_d     = dat_q;
    pop       = 1'b0;
    issue     = 1'b0;
    issue_dat = 9'd0;
`ifdef LCD_INIT_EN
    init_idx_d  = init_idx_q;
    init_pend_d = init_pend_q;
`endif
    case (state_q)
      S_IDLE: begin
`ifdef LCD_INIT_EN
        if (init_pend_q) begin
          issue      = 1'b1;
          issue_dat  = {1'b0, init_byte};
          init_idx_d = init_idx_q + 1'b1;
          if (init_idx_q == 2'd3) init_pend_d = 1'b0;
        end else
`endif
        if (!fifo_empty) begin
          issue     = 1'b1;
          pop       = 1'b1;
          issue_dat = fifo_dat;
        end
      end
      S_SETUP: begin
        if (cnt_q == '0) begin
          e_d     = 1'b1;
          cnt_d   = CW'(T_EPW - 1);
          state_d = S_PULSE;
        end else cnt_d = cnt_q - 1'b1;
      end
      S_PULSE: begin
        if (cnt_q == '0) begin
          e_d     = 1'b0;
          cnt_d   = CW'(T_HOLD - 1);
          state_d = S_HOLD;
        end else cnt_d = cnt_q - 1'b1;
      end
      S_HOLD: begin
        if (cnt_q == '0) begin
          cnt_d   = long_wait ? CW'(CLR_WAIT - 1) : CW'(CMD_WAIT - 1);
          state_d = S_WAIT;
        end else cnt_d = cnt_q - 1'b1;
      end
`ifdef LCD_INIT_EN
      S_WAIT, S_PWRUP: begin
`else
      S_WAIT: begin
`endif
        if (cnt_q == '0) state_d = S_IDLE;
        else cnt_d = cnt_q - 1'b1;
      end
      default: begin
        state_d = S_IDLE;
        e_d     = 1'b0;
      end
    endcase
    if (issue) begin
      {rs_d, dat_d} = issue_dat;
      cnt_d         = CW'(T_AS - 1);
      state_d       = S_SETUP;
    end
  end

  // Overflow set wins over a same-cycle status read so no drop goes unreported.
  always_comb begin
    ovf_d = ovf_q;
    if (read && address == 2'd2) ovf_d = 1'b0;
    if (push && fifo_full)       ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RST_STATE;
      cnt_q   <= RST_CNT;
      e_q     <= 1'b0;
      rs_q    <= 1'b0;
      dat_q   <= 8'd0;
      ovf_q   <= 1'b0;
`ifdef LCD_INIT_EN
      init_idx_q  <= 2'd0;
      init_pend_q <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      e_q     <= e_d;
      rs_q    <= rs_d;
      dat_q   <= dat_d;
      ovf_q   <= ovf_d;
`ifdef LCD_INIT_EN
      init_idx_q  <= init_idx_d;
      init_pend_q <= init_pend_d;
`endif
    end
  end

  assign lvl_sat  = (32'(fifo_lvl) > 32'd15) ? 4'hF : 4'(fifo_lvl);
  assign readdata = (address == 2'd2) ? {lvl_sat, ovf_q, fifo_empty, fifo_full, busy} : 8'd0;

  assign LCD_E    = e_q;
  assign LCD_RS   = rs_q;
  assign LCD_RW   = 1'b0;
  assign LCD_data = dat_q;
endmodule
